// File: rtl/tmds_pkg.sv
// tmds_pkg: shared TMDS constants and types; holds the 10-bit symbol type, the running-disparity type, the control tokens and the TERC4 LUT used when TMDS_TERC4_EN is defined.
package tmds_pkg;
  localparam int CNT_W_DEF = 5;
  typedef logic [9:0] sym_t;
  typedef logic signed [CNT_W_DEF-1:0] cnt_t;
  localparam sym_t CTRL_TOK0 = 10'b1101010100;
  localparam sym_t CTRL_TOK1 = 10'b0010101011;
  localparam sym_t CTRL_TOK2 = 10'b0101010100;
  localparam sym_t CTRL_TOK3 = 10'b1010101011;
  localparam sym_t TERC4_LUT [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    popcount8 = '0;
    for (int i = 0; i < 8; i++) popcount8 = popcount8 + {3'b0, v[i]};
  endfunction
endpackage

// File: rtl/tm_choice.sv
// tm_choice: TMDS transition-minimisation stage; data_in[7:0] pixel byte -> qm_out[8:0], qm_out[8]=1 when XOR chaining was used, 0 for XNOR.
module tm_choice (
  input  logic [7:0] data_in,
  output logic [8:0] qm_out
);
  logic [3:0] n1;
  logic       xn;
  logic [8:0] q;
  always_comb begin
    n1 = '0;
    for (int i = 0; i < 8; i++) n1 = n1 + {3'b0, data_in[i]};
    xn = (n1 > 4'd4) || (n1 == 4'd4 && !data_in[0]);
    q = '0;
    q[0] = data_in[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ data_in[i]) : (q[i-1] ^ data_in[i]);
    q[8] = ~xn;
    qm_out = q;
  end
endmodule

// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI/HDMI TMDS channel encoder with 2-cycle latency.
// Ports: clk_in, rst_n_in (async active-low), data_in[7:0], control_in[1:0], ve_in,
//   tmds_out[9:0] (bit 0 sent first), disparity_out[CNT_W-1:0] (signed running disparity).
// Macro TMDS_TERC4_EN adds di_in and terc4_in[3:0] for TERC4 data-island symbols.
module tmds_encoder
  import tmds_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [7:0]              data_in,
  input  logic [1:0]              control_in,
  input  logic                    ve_in,
  output sym_t                    tmds_out,
  output logic signed [CNT_W-1:0] disparity_out
`ifdef TMDS_TERC4_EN
  ,
  input  logic                    di_in,
  input  logic [3:0]              terc4_in
`endif
);
  logic [8:0]              qm_d, qm_q;
  logic                    ve_q;
  logic [1:0]              ctrl_q;
  sym_t                    tmds_d, tmds_q;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic [3:0]              n1;
  logic signed [CNT_W:0]   diff, cnt_x, two_hi, two_lo, sum;
  logic                    bal, inv;
  sym_t                    vid_sym, ctl_sym;
`ifdef TMDS_TERC4_EN
  logic                    di_q;
  logic [3:0]              terc4_q;
`endif
  tm_choice u_tm (
    .data_in (data_in),
    .qm_out  (qm_d)
  );
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      qm_q    <= '0;
      ve_q    <= 1'b0;
      ctrl_q  <= '0;
      tmds_q  <= '0;
      cnt_q   <= '0;
`ifdef TMDS_TERC4_EN
      di_q    <= 1'b0;
      terc4_q <= '0;
`endif
    end else begin
      qm_q    <= qm_d;
      ve_q    <= ve_in;
      ctrl_q  <= control_in;
      tmds_q  <= tmds_d;
      cnt_q   <= cnt_d;
`ifdef TMDS_TERC4_EN
      di_q    <= di_in;
      terc4_q <= terc4_in;
`endif
    end
  end
  // diff = N1 - N0 = 2*N1 - 8; all balance math runs one bit wider than cnt
  always_comb begin
    n1      = popcount8(qm_q[7:0]);
    diff    = (CNT_W+1)'({n1, 1'b0}) - (CNT_W+1)'(8);
    cnt_x   = {cnt_q[CNT_W-1], cnt_q};
    two_hi  = (CNT_W+1)'({qm_q[8], 1'b0});
    two_lo  = (CNT_W+1)'({~qm_q[8], 1'b0});
    bal     = (n1 == 4'd4) || ~|cnt_q;
    inv     = (!cnt_q[CNT_W-1] && |cnt_q && n1 > 4'd4) || (cnt_q[CNT_W-1] && n1 < 4'd4);
    sum     = bal ? cnt_x + (qm_q[8] ? diff : -diff)
            : inv ? cnt_x + two_hi - diff
            : cnt_x - two_lo + diff;
    vid_sym = bal ? {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]}
            : {inv, qm_q[8], inv ? ~qm_q[7:0] : qm_q[7:0]};
    ctl_sym = ctrl_q[1] ? (ctrl_q[0] ? CTRL_TOK3 : CTRL_TOK2)
            : (ctrl_q[0] ? CTRL_TOK1 : CTRL_TOK0);
`ifdef TMDS_TERC4_EN
    ctl_sym = di_q ? TERC4_LUT[terc4_q] : ctl_sym;
`endif
    tmds_d  = ve_q ? vid_sym : ctl_sym;
    cnt_d   = ve_q ? sum[CNT_W-1:0] : '0;
  end
  assign tmds_out      = tmds_q;
  assign disparity_out = cnt_q;
endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder: self-checking bench for tmds_encoder against a behavioural TMDS model.
module tb_tmds_encoder;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        data_in;
  logic [1:0]        control_in;
  logic              ve_in;
  logic [9:0]        tmds_out;
  logic signed [4:0] disparity_out;
`ifdef TMDS_TERC4_EN
  logic              di_in = 1'b0;
  logic [3:0]        terc4_in = 4'd0;
`endif
  int                n_chk = 0, n_pass = 0;
  int                m_cnt;
  bit                m_ve;
  bit [1:0]          m_c;
  bit [7:0]          m_d;
  bit [9:0]          exp_sym;
  int                exp_cnt;
  always #5 clk = ~clk;
  tmds_encoder #(.CNT_W(5)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .data_in       (data_in),
    .control_in    (control_in),
    .ve_in         (ve_in),
    .tmds_out      (tmds_out),
    .disparity_out (disparity_out)
`ifdef TMDS_TERC4_EN
    ,
    .di_in         (di_in),
    .terc4_in      (terc4_in)
`endif
  );
  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask
  function automatic bit [9:0] ref_enc(input bit ve, input bit [1:0] c, input bit [7:0] d);
    bit [9:0] tok [4];
    bit [8:0] q;
    bit       xn;
    int       ones, n1, n0;
    tok = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    if (!ve) begin
      m_cnt = 0;
      return tok[c];
    end
    ones = $countones(d);
    xn = (ones > 4) || (ones == 4 && !d[0]);
    q = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = q[i-1] ^ d[i] ^ xn;
    q[8] = !xn;
    n1 = $countones(q[7:0]);
    n0 = 8 - n1;
    if (m_cnt == 0 || n1 == n0) begin
      m_cnt += q[8] ? n1 - n0 : n0 - n1;
      return {!q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
    end
    if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
      m_cnt += 2 * int'(q[8]) + n0 - n1;
      return {1'b1, q[8], ~q[7:0]};
    end
    m_cnt += -2 * int'(!q[8]) + n1 - n0;
    return {1'b0, q[8], q[7:0]};
  endfunction
  task automatic step(input bit ve, input bit [1:0] c, input bit [7:0] d);
    ve_in = ve;
    control_in = c;
    data_in = d;
    @(posedge clk);
    exp_sym = ref_enc(m_ve, m_c, m_d);
    exp_cnt = m_cnt;
    m_ve = ve;
    m_c = c;
    m_d = d;
    #1;
    check("sym", int'(tmds_out), int'(exp_sym));
    check("cnt", int'(disparity_out), exp_cnt);
  endtask
  task automatic model_reset();
    m_cnt = 0;
    m_ve = 0;
    m_c = 0;
    m_d = 0;
  endtask
  initial begin
    rst_n = 1'b0;
    ve_in = 1'b0;
    control_in = 2'b00;
    data_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sym", int'(tmds_out), 0);
    check("rst_cnt", int'(disparity_out), 0);
    #2 rst_n = 1'b1;
    step(0, 2'b00, 8'h00); check("rel_tok00", int'(tmds_out), 'b1101010100);
    step(0, 2'b01, 8'h00);
    step(0, 2'b10, 8'h00); check("tok01", int'(tmds_out), 'b0010101011);
    step(0, 2'b11, 8'h00); check("tok10", int'(tmds_out), 'b0101010100);
    step(0, 2'b00, 8'h00); check("tok11", int'(tmds_out), 'b1010101011);
    check("tok_cnt", int'(disparity_out), 0);
    step(1, 2'b00, 8'h00);
    step(1, 2'b00, 8'h00); check("z0_sym", int'(tmds_out), 'b0100000000); check("z0_cnt", int'(disparity_out), -8);
    step(1, 2'b00, 8'h00); check("z1_sym", int'(tmds_out), 'b1111111111); check("z1_cnt", int'(disparity_out), 2);
    step(0, 2'b00, 8'h00); check("z2_sym", int'(tmds_out), 'b0100000000); check("z2_cnt", int'(disparity_out), -6);
    step(1, 2'b00, 8'hFF);
    step(0, 2'b00, 8'h00); check("ff_sym", int'(tmds_out), 'b1000000000); check("ff_cnt", int'(disparity_out), -8);
    step(1, 2'b00, 8'h00);
    step(0, 2'b00, 8'h00); check("c0_sym", int'(tmds_out), 'b0100000000); check("c0_cnt", int'(disparity_out), -8);
    step(1, 2'b00, 8'h00); check("clr_cnt", int'(disparity_out), 0);
    step(0, 2'b00, 8'h00); check("c1_sym", int'(tmds_out), 'b0100000000); check("c1_cnt", int'(disparity_out), -8);
    for (int i = 0; i < 400; i++) step($urandom_range(0, 4) != 0, 2'($urandom), 8'($urandom));
    #2 rst_n = 1'b0;
    #1;
    check("arst_sym", int'(tmds_out), 0);
    check("arst_cnt", int'(disparity_out), 0);
    model_reset();
    #1 rst_n = 1'b1;
    step(1, 2'b00, 8'($urandom)); check("arst_tok00", int'(tmds_out), 'b1101010100);
    for (int i = 0; i < 200; i++) step($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom));
    for (int i = 0; i < 60; i++) step(i[0], 2'($urandom), 8'($urandom));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/tmds_encoder.md
Name: tmds_encoder

Overview:
- Full DVI/HDMI TMDS channel encoder: 8-bit pixel or 2-bit control in, 10-bit TMDS symbol out.
- Stage 1 is the existing transition-minimization stage, tm_choice (8→9 bit).
- This block registers the tm_choice result, applies running-disparity DC balancing, and substitutes control tokens during blanking.
- One instance per colour channel; the output feeds the 10:1 serializer.

Parameters:
- CNT_W, 5, width of the signed running-disparity counter (two's complement).

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous, active-low reset
- data_in  input  8  pixel byte, used when ve_in=1
- control_in  input  2  {C1,C0} control bits, used when ve_in=0
- ve_in  input  1  video-enable / data-enable
- tmds_out  output  10  encoded symbol, bit 0 is transmitted first
- disparity_out  output  CNT_W  current running disparity, signed; for debug and verification

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low: rst_n_in=0 forces all flops to zero immediately, without waiting for a clock edge.
- Reset values:
  - tmds_out=10'b0, disparity_out=0.
  - Stage-1 registers qm_r=0, ve_r=0, ctrl_r=0.
- Pipeline, fixed latency 2 cycles (inputs sampled at edge k appear on tmds_out after edge k+1):
  - Stage 1 at edge k: tm_choice(data_in) is captured to qm_r[8:0]; ve_in→ve_r; control_in→ctrl_r.
  - Stage 2 at edge k+1: tmds_out and cnt are updated from the stage-1 registers.
- Stage 2 uses N1 = popcount(qm_r[7:0]) and N0 = 8−N1. Arithmetic is done at CNT_W+1 bits signed, then truncated to CNT_W. |cnt|≤10 is guaranteed by the algorithm, so no overflow occurs.
- ve_r=0 (control period): cnt←0, and tmds_out gets the token for ctrl_r:
  - 00→1101010100
  - 01→0010101011
  - 10→0101010100
  - 11→1010101011
- ve_r=1, case cnt==0 or N1==N0:
  - tmds_out={~qm[8], qm[8], qm[8]?qm[7:0]:~qm[7:0]}.
  - cnt += qm[8] ? (N1−N0) : (N0−N1).
- ve_r=1, case (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
  - tmds_out={1, qm[8], ~qm[7:0]}.
  - cnt += 2·qm[8] + (N0−N1).
- ve_r=1, otherwise:
  - tmds_out={0, qm[8], qm[7:0]}.
  - cnt += −2·(~qm[8]) + (N1−N0).
- Boundary conditions:
  - ve_in toggles every cycle: each symbol follows its own ve_r, with no extra bubble.
  - A control period of any length, including one cycle, zeroes cnt.
  - Reset asserted mid-stream: tmds_out goes to 0 immediately. After release, the first symbol (one edge later) is the 00 token, because ve_r=0 and ctrl_r=00.

Optional Feature:
- Macro: TMDS_TERC4_EN.
- Defined:
  - Adds input di_in (1 bit) and input terc4_in (4 bits).
  - These are registered through stage 1 alongside the other inputs.
  - When ve_r=0 and di_r=1, tmds_out is the TERC4 LUT entry for terc4_r; cnt←0.
  - di has lower priority than ve (ve_r=1 always selects video encoding).
  - LUT values follow HDMI 1.4 Table 5-18, 0000→1010011100 … 1111→1011000011.
- Undefined: the ports are absent and behaviour is exactly as above.

Decomposition:
- Package tmds_pkg holds:
  - localparam constants for the four control tokens;
  - the 16-entry TERC4 LUT as a localparam array;
  - a typedef for the 10-bit symbol;
  - a typedef for the CNT_W signed counter.
- Sub-module: reuse tm_choice unchanged as stage 1.
- Popcount and balance logic stay inline in tmds_encoder.

Test Plan:
- Reset, then release with ve_in=0, control_in=00 held:
  - tmds_out=0 and disparity_out=0 during reset;
  - 1101010100 appears one edge after release.
- ve_in=0, control_in=01,10,11 on successive cycles:
  - tmds_out=0010101011, 0101010100, 1010101011, each 2 cycles after its input;
  - disparity_out=0 throughout.
- ve_in=1, data_in=0x00 for three cycles starting from cnt 0:
  - tmds_out sequence 0100000000, 1111111111, 0100000000;
  - disparity_out sequence −8, +2, −6.
- Single data_in=0xFF from cnt 0: tmds_out=1000000000, disparity_out=−8.
- ve_in=1 with 0x00 (cnt→−8), then one ve_in=0 cycle, then 0x00 again:
  - symbols are 0100000000, control token, 0100000000;
  - cnt is back at −8, proving it was cleared by the control cycle.
- Async reset mid-stream:
  - pulse rst_n_in low between clock edges;
  - tmds_out=0 and disparity_out=0 before the next edge;
  - normal encoding resumes 2 cycles after release.
